permutation_round_sequencer: RTL and testbench

Parametrised round sequencer for the permutation core. It replaces the single-mode free-running round counter with a start/done handshake, a per-invocation round-count mode, stall and abort control, and unrolled stepping of several rounds per cycle. It also provides the round-constant index and first/last-round flags the permutation datapath consumes directly. It sits between the sponge/KEM controller and the permutation round logic.

---
 rtl/perm_seq_pkg.sv | 27 ++
 rtl/round_step_counter.sv | 41 ++++
 rtl/permutation_round_sequencer.sv | 130 +++++++++++++
 tb/tb_permutation_round_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/perm_seq_pkg.sv
// Shared definitions for the permutation round sequencer and the permutation datapath:
// sequencer states, round-count mode encodings and the mode-to-round-count lookup.
package perm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  function automatic int rounds_for_mode(input logic [1:0] mode,
                                         input int r0, input int r1,
                                         input int r2, input int r3);
    case (mode)
      MODE_0:  return r0;
      MODE_1:  return r1;
      MODE_2:  return r2;
      default: return r3;
    endcase
  endfunction

endpackage

// File: rtl/round_step_counter.sv
// Round position counter: load-zero / hold / add-STEP, with a compare that flags
// the step whose rounds end exactly at the limit.
module round_step_counter #(
  parameter int CTR_WIDTH = 5,
  parameter int STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_zero_i,
  input  logic                 advance_i,
  input  logic [CTR_WIDTH-1:0] limit_i,
  output logic [CTR_WIDTH-1:0] count_o,
  output logic                 terminal_o
);

  localparam logic [CTR_WIDTH:0] STEP_W = (CTR_WIDTH + 1)'(STEP);

  logic [CTR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_zero_i) begin
      cnt_d = '0;
    end else if (advance_i) begin
      cnt_d = cnt_q + STEP_W[CTR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One extra bit so the compare cannot alias on overflow.
  assign terminal_o = (({1'b0, cnt_q} + STEP_W) == {1'b0, limit_i});
  assign count_o    = cnt_q;

endmodule

// File: rtl/permutation_round_sequencer.sv
// Start/done round sequencer for the permutation core: per-run round-count mode,
// stall/abort, unrolled stepping, and round-constant index plus first/last flags.
module permutation_round_sequencer
  import perm_seq_pkg::*;
#(
  parameter int CTR_WIDTH        = 5,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int ROUNDS_0         = 12,
  parameter int ROUNDS_1         = 8,
  parameter int ROUNDS_2         = 6,
  parameter int ROUNDS_3         = 12,
  parameter int RC_BASE          = 12,
  parameter int DONE_CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic                      stall,
  input  logic                      abort,
  output logic                      busy,
  output logic [CTR_WIDTH-1:0]      round_idx,
  output logic [CTR_WIDTH-1:0]      rc_index,
  output logic                      first_round,
  output logic                      last_round,
  output logic                      done,
  output logic [DONE_CNT_WIDTH-1:0] done_count
);

  if (ROUNDS_PER_CYCLE < 1) begin : g_bad_unroll
    $fatal(1, "ROUNDS_PER_CYCLE must be at least 1");
  end
  if (RC_BASE >= (1 << CTR_WIDTH)) begin : g_bad_width
    $fatal(1, "CTR_WIDTH too narrow for RC_BASE");
  end
  for (genvar k = 0; k < 4; k++) begin : g_mode_chk
    localparam int R = rounds_for_mode(2'(k), ROUNDS_0, ROUNDS_1, ROUNDS_2, ROUNDS_3);
    if (R < 1 || R > RC_BASE || (R % ROUNDS_PER_CYCLE) != 0) begin : g_bad
      $fatal(1, "illegal round count for a mode");
    end
  end

  localparam logic [CTR_WIDTH-1:0] RC_BASE_W = CTR_WIDTH'(RC_BASE);

  seq_state_e                state_q, state_d;
  logic [CTR_WIDTH-1:0]      nr_q;
  logic [DONE_CNT_WIDTH-1:0] done_cnt_q;
  logic [CTR_WIDTH-1:0]      cnt;
  logic                      terminal;
  logic                      accept;
  logic                      advance;
  logic                      finish;

  assign accept  = start && (state_q == IDLE || state_q == DONE);
  assign advance = (state_q == RUN) && !abort && !stall;
  assign finish  = advance && terminal;

  round_step_counter #(
    .CTR_WIDTH (CTR_WIDTH),
    .STEP      (ROUNDS_PER_CYCLE)
  ) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .load_zero_i (accept),
    .advance_i   (advance),
    .limit_i     (nr_q),
    .count_o     (cnt),
    .terminal_o  (terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort outranks stall, and stall outranks completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (stall)    state_d = RUN;
        else if (terminal) state_d = DONE;
      end
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    round_idx   = '0;
    rc_index    = '0;
    first_round = 1'b0;
    last_round  = 1'b0;
    case (state_q)
      RUN: begin
        busy        = 1'b1;
        round_idx   = cnt;
        rc_index    = RC_BASE_W - nr_q + cnt;
        first_round = (cnt == '0);
        last_round  = terminal;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      nr_q <= CTR_WIDTH'(rounds_for_mode(mode, ROUNDS_0, ROUNDS_1, ROUNDS_2, ROUNDS_3));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else if (finish) begin
      done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign done_count = done_cnt_q;

endmodule

// File: tb/tb_permutation_round_sequencer.sv
// Bench for permutation_round_sequencer: two instances (unroll 1 with narrow done
// counter, unroll 2) share stimulus and are checked against a transaction model.
module tb_permutation_round_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stall, abort;
  logic [1:0] mode;

  logic        busy_w[2], first_w[2], last_w[2], done_w[2];
  logic [4:0]  ridx_w[2], rc_w[2];
  logic [3:0]  dca;
  logic [15:0] dcb;

  always #5 clk = ~clk;

  permutation_round_sequencer #(
    .ROUNDS_PER_CYCLE (1),
    .DONE_CNT_WIDTH   (4)
  ) dut_a (
    .clk (clk), .rst (rst), .start (start), .mode (mode), .stall (stall), .abort (abort),
    .busy (busy_w[0]), .round_idx (ridx_w[0]), .rc_index (rc_w[0]),
    .first_round (first_w[0]), .last_round (last_w[0]), .done (done_w[0]),
    .done_count (dca)
  );

  permutation_round_sequencer #(
    .ROUNDS_PER_CYCLE (2)
  ) dut_b (
    .clk (clk), .rst (rst), .start (start), .mode (mode), .stall (stall), .abort (abort),
    .busy (busy_w[1]), .round_idx (ridx_w[1]), .rc_index (rc_w[1]),
    .first_round (first_w[1]), .last_round (last_w[1]), .done (done_w[1]),
    .done_count (dcb)
  );

  // Model: phase 0 idle, 1 running, 2 finished; pos counts completed steps.
  localparam int RC = 12;
  int rtab[4]  = '{12, 8, 6, 12};
  int uu[2]    = '{1, 2};
  int dcmod[2] = '{16, 65536};
  int ph[2], pos[2], nr[2], dc[2];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      string p;
      bit    run;
      p   = (i == 0) ? "a" : "b";
      run = (ph[i] == 1);
      check({p, ".busy"},  32'(busy_w[i]),  32'(run));
      check({p, ".done"},  32'(done_w[i]),  32'(ph[i] == 2));
      check({p, ".ridx"},  32'(ridx_w[i]),  run ? 32'(pos[i] * uu[i]) : 32'd0);
      check({p, ".rc"},    32'(rc_w[i]),    run ? 32'(RC - nr[i] + pos[i] * uu[i]) : 32'd0);
      check({p, ".first"}, 32'(first_w[i]), 32'(run && pos[i] == 0));
      check({p, ".last"},  32'(last_w[i]),  32'(run && (pos[i] + 1) * uu[i] == nr[i]));
      check({p, ".dcnt"},  (i == 0) ? 32'(dca) : 32'(dcb), 32'(dc[i]));
    end
  endtask

  task automatic step(input bit s, input logic [1:0] m, input bit st, input bit ab, input bit r);
    compare_all();
    start = s; mode = m; stall = st; abort = ab; rst = r;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        ph[i] = 0; pos[i] = 0; dc[i] = 0;
      end else if (ph[i] == 1) begin
        if (ab) ph[i] = 0;
        else if (!st) begin
          if ((pos[i] + 1) * uu[i] == nr[i]) begin
            ph[i] = 2;
            dc[i] = (dc[i] + 1) % dcmod[i];
          end else begin
            pos[i]++;
          end
        end
      end else if (s) begin
        ph[i] = 1; pos[i] = 0; nr[i] = rtab[m];
      end else begin
        ph[i] = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; stall = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; pos[i] = 0; nr[i] = 1; dc[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    step(0, 0, 0, 0, 0);

    // Mode 0: unroll-1 instance finishes after 12 run cycles.
    step(1, 0, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0, 0);
    check("a.done_c13", 32'(done_w[0]), 32'd1);
    check("a.dcnt_c13", 32'(dca), 32'd1);
    repeat (2) step(0, 0, 0, 0, 0);

    // Mode 2.
    step(1, 2, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0);

    // Mode 1 with three stall cycles at round 4 of the unroll-1 instance.
    step(1, 1, 0, 0, 0);
    repeat (4) step(0, 3, 0, 0, 0);
    repeat (3) step(0, 3, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);

    // Start held high: back-to-back restarts, pulses during RUN ignored.
    repeat (24) step(1, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    // Abort mid-run, then reset mid-run.
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0);

    // Randomised traffic; the 4-bit counter wraps many times.
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 99) < 40, 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
           $urandom_range(0, 999) < 5);
    end
    compare_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
